ezlogic_top: RTL and testbench

- Byte-stream obfuscation core.
- Each accepted input byte is chained with the previously accepted byte, rotated by the stream position, and offset by the stream index.
- Sits between a byte-serial producer (valid-qualified, no backpressure) and a checker that collects output bytes in order and compares them against a stored digest.
- Fixed two-cycle pipeline; one output byte per accepted input byte, in order.

---
 rtl/ezlogic_top.sv | 114 +++++++++++
 tb/tb_ezlogic_top.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ezlogic_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ezlogic_top                                                     |
// | Purpose  : Byte-stream obfuscation core. Each accepted byte is XOR-chained |
// |            with the previously accepted raw byte, rotated left by the low  |
// |            three bits of its stream index, then offset by the index.       |
// |            Two register stages: stage 1 captures the rotated byte and the |
// |            index, stage 2 (the output register) adds them. A byte sampled |
// |            on edge k is loaded into the output register on edge k+1, so a |
// |            consumer on the same clock captures it on edge k+2.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ezlogic_top #(
  parameter int unsigned IDX_W     = 8,
  parameter logic [7:0]  INIT_PREV = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,      // active-high asynchronous reset despite the name
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out
);

  // Chaining and index state
  logic [7:0]       prev_q;
  logic [7:0]       prev_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Stage-1 pipeline registers
  logic [7:0]       s1_rot_q;
  logic [7:0]       s1_idx_q;
  logic             s1_vld_q;

  // Stage-2 (output) registers
  logic [7:0]       dout_q;
  logic             vout_q;

  // Combinational transform terms
  logic [7:0]       idx8;       // index reduced mod 256 for the additive offset
  logic [2:0]       rot_amt;    // only the low three index bits steer the rotate
  logic [7:0]       chain_x;
  logic [7:0]       rot_r;

  // The offset always uses the index mod 256; narrower counters zero-extend.
  generate
    if (IDX_W >= 8) begin : g_idx_trunc
      assign idx8 = idx_q[7:0];
    end else begin : g_idx_ext
      assign idx8 = {{(8 - IDX_W){1'b0}}, idx_q};
    end
  endgenerate

  assign rot_amt = idx_q[2:0];
  assign chain_x = data_in ^ prev_q;

  // Rotate-left; a zero amount shifts the wrap-around term fully out.
  assign rot_r = (chain_x << rot_amt) | (chain_x >> (4'd8 - {1'b0, rot_amt}));

  // Next-state for chaining value and index: advance only on an accepted byte
  always_comb begin
    prev_d = prev_q;
    idx_d  = idx_q;
    if (valid_in) begin
      prev_d = data_in;             // chain on the raw byte, not the XOR result
      idx_d  = idx_q + IDX_W'(1);   // wraps naturally at 2^IDX_W
    end
  end

  // Chaining value and stream index registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prev_q <= INIT_PREV;
      idx_q  <= '0;
    end else begin
      prev_q <= prev_d;
      idx_q  <= idx_d;
    end
  end

  // Stage 1: capture rotated byte and its index; data holds across bubbles
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_rot_q <= 8'h00;
      s1_idx_q <= 8'h00;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= valid_in;
      if (valid_in) begin
        s1_rot_q <= rot_r;
        s1_idx_q <= idx8;
      end
    end
  end

  // Stage 2: add the index offset; output data holds its last value in bubbles
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dout_q <= 8'h00;
      vout_q <= 1'b0;
    end else begin
      vout_q <= s1_vld_q;
      if (s1_vld_q) begin
        dout_q <= s1_rot_q + s1_idx_q;
      end
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;

endmodule
`default_nettype wire

// File: tb/tb_ezlogic_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ezlogic_top                                                  |
// | Purpose  : Directed self-checking bench for ezlogic_top. Inputs are driven |
// |            on the falling edge; outputs are sampled 1 time unit after the  |
// |            rising edge against a queue of expected bytes and due cycles.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ezlogic_top;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;

  ezlogic_top #(
    .IDX_W     (8),
    .INIT_PREV (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t         q[$];
  int           n_chk   = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           pulses  = 0;
  logic [7:0]   m_prev  = 8'h00;
  logic [7:0]   m_idx   = 8'h00;
  logic [7:0]   last_out = 8'h00;
  logic         collect = 1'b0;
  logic [335:0] got_dig = '0;
  logic [335:0] exp_dig = '0;

  task automatic check(input string tag, input logic [335:0] got, input logic [335:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference transform written from the formula
  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] prev,
                                       input logic [7:0] idx);
    logic [7:0]  x;
    logic [15:0] w;
    x = d ^ prev;
    w = {x, x} << idx[2:0];
    return w[15:8] + idx;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle; on a valid byte queue its expected value and due cycle
  task automatic send(input logic v, input logic [7:0] d, input logic use_hand,
                      input logic [7:0] hand, output logic [7:0] e);
    exp_t it;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    e        = 8'h00;
    if (v) begin
      e      = use_hand ? hand : model(d, m_prev, m_idx);
      it.d   = e;
      it.due = cyc + 2;
      q.push_back(it);
      m_prev = d;
      m_idx  = m_idx + 8'd1;
    end
  endtask

  task automatic send_h(input logic [7:0] d, input logic [7:0] hand);
    logic [7:0] e;
    send(1'b1, d, 1'b1, hand, e);
  endtask

  task automatic idle(input int n);
    logic [7:0] e;
    repeat (n) send(1'b0, 8'h00, 1'b0, 8'h00, e);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    q.delete();
    m_prev   = 8'h00;
    m_idx    = 8'h00;
    repeat (ncyc) @(negedge clk);
    rst_n    = 1'b0;
  endtask

  // Output monitor: reset values, expected bytes with latency, hold in bubbles
  always begin : mon
    exp_t it;
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("rst_dout", data_out, 8'h00);
      check("rst_vout", valid_out, 1'b0);
      last_out = 8'h00;
    end else if (valid_out) begin
      pulses++;
      if (q.size() == 0) begin
        check("spurious_vout", valid_out, 1'b0);
      end else begin
        it = q.pop_front();
        check("latency", cyc, it.due);
        check("dout", data_out, it.d);
      end
      last_out = data_out;
      if (collect) got_dig = {got_dig[327:0], data_out};
    end else begin
      check("hold", data_out, last_out);
    end
  end

  initial begin : stim
    string      flag;
    logic [7:0] e;
    flag = "0ops{chained_rotate_offset_stream_cipher_}";

    // Reset, then "0op" back-to-back
    do_reset(2);
    send_h(8'h30, 8'h30);
    send_h(8'h6F, 8'hBF);
    send_h(8'h70, 8'h7E);
    idle(4);

    // 42-byte flag string, packed MSB-first and compared as a digest
    do_reset(2);
    pulses  = 0;
    got_dig = '0;
    exp_dig = '0;
    collect = 1'b1;
    for (int i = 0; i < flag.len(); i++) begin
      send(1'b1, flag[i], 1'b0, 8'h00, e);
      exp_dig = {exp_dig[327:0], e};
    end
    idle(4);
    collect = 1'b0;
    check("flag_pulses", pulses, 42);
    check("flag_digest", got_dig, exp_dig);

    // 300 zero bytes: output equals index mod 256, across the wrap
    do_reset(2);
    for (int i = 0; i < 300; i++) send_h(8'h00, 8'(i));
    idle(4);

    // FF with idle gaps; data_out holds between strobes
    do_reset(2);
    send_h(8'hFF, 8'hFF);
    idle(1);
    send_h(8'hFF, 8'h01);
    idle(1);
    send_h(8'hFF, 8'h02);
    idle(4);

    // Mid-stream reset with bytes in flight
    do_reset(2);
    send_h(8'hAA, 8'hAA);
    send_h(8'h11, 8'h78);
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h22;
    q.delete();
    m_prev   = 8'h00;
    m_idx    = 8'h00;
    #1;
    check("async_dout", data_out, 8'h00);
    check("async_vout", valid_out, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    send_h(8'h30, 8'h30);
    idle(4);

    // Reset held while valid_in toggles data
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_prev = 8'h00;
    m_idx  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = (k % 2 == 0) ? 8'hA5 : 8'h5A;
    end
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    idle(3);

    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
